// File: rtl/io_pkg.sv
// io_pkg
//   Shared constants for the CPU input-port controller.
//   IO_*_ADDR are the word-address codes compared against addr[7:2].
package io_pkg;

    localparam int PORT_W_DEFAULT = 5;

    localparam logic [5:0] IO_PORT0_ADDR  = 6'b100000;  // byte address 0x80
    localparam logic [5:0] IO_PORT1_ADDR  = 6'b100001;  // byte address 0x84
    localparam logic [5:0] IO_STATUS_ADDR = 6'b100010;  // byte address 0x88

endpackage

// File: rtl/io_debounce.sv
// io_debounce
//   Two-flop synchroniser followed by a stability counter. A new value is
//   committed to 'stable' once the synchronised input has matched the
//   candidate for DB_CYCLES consecutive edges.
//   Ports:
//     clk     in  1       clock
//     resetn  in  1       synchronous active-low reset
//     pin     in  PORT_W  raw asynchronous input
//     stable  out PORT_W  debounced value
//     commit  out 1       high in the cycle whose rising edge commits a new value
module io_debounce #(
    parameter int PORT_W    = 5,
    parameter int DB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [PORT_W-1:0] pin,
    output logic [PORT_W-1:0] stable,
    output logic              commit
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [PORT_W-1:0] s1, s2, cand;
    logic [CW-1:0]     cnt;

    // Commit is decided combinationally so the parent can set its sticky flag
    // on the same edge that updates 'stable'.
    assign commit = (s2 == cand) && (cand != stable) && (cnt == CW'(DB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cand != stable) begin
                if (commit) begin
                    stable <= cand;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sevenseg.sv
// sevenseg
//   Decimal digit to seven-segment code, active high, bit order {g,f,e,d,c,b,a}.
//   Codes above 9 blank the display.
//   Ports:
//     digit  in  4  decimal digit 0..9
//     seg    out 7  segment pattern
module sevenseg (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        case (digit)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/io_input_ctrl.sv
// io_input_ctrl
//   Memory-mapped input controller: debounces two switch ports, keeps sticky
//   new-data flags, answers CPU reads one cycle later and scans four decimal
//   digits onto a shared seven-segment bus.
//   Ports:
//     clk        in  1       clock
//     resetn     in  1       synchronous active-low reset
//     addr       in  32      CPU address, addr[7:2] decoded
//     rd_en      in  1       read strobe
//     in_port0   in  PORT_W  raw port 0
//     in_port1   in  PORT_W  raw port 1
//     io_data    out 32      registered read data
//     rd_valid   out 1       io_data valid pulse
//     irq        out 1       any new-data flag set
//     digit_sel  out 4       one-hot digit enable
//     seg        out 7       segment code of the selected digit
module io_input_ctrl
    import io_pkg::*;
#(
    parameter int PORT_W    = PORT_W_DEFAULT,
    parameter int DB_CYCLES = 4,
    parameter int SCAN_DIV  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       addr,
    input  logic              rd_en,
    input  logic [PORT_W-1:0] in_port0,
    input  logic [PORT_W-1:0] in_port1,
    output logic [31:0]       io_data,
    output logic              rd_valid,
    output logic              irq,
    output logic [3:0]        digit_sel,
    output logic [6:0]        seg
);

    localparam int SW = $clog2(SCAN_DIV);

    logic [PORT_W-1:0] stable0, stable1;
    logic              commit0, commit1;
    logic              new0, new1, new0_nxt, new1_nxt;
    logic              clr0, clr1;
    logic [5:0]        word;
    logic [31:0]       rd_mux;
    logic [SW-1:0]     scan_cnt;
    logic [1:0]        index;
    logic [3:0]        digit;
    logic [PORT_W-1:0] d0, d1, d2, d3;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:8], addr[1:0]};

    io_debounce #(.PORT_W(PORT_W), .DB_CYCLES(DB_CYCLES)) u_db0 (
        .clk(clk), .resetn(resetn), .pin(in_port0), .stable(stable0), .commit(commit0)
    );

    io_debounce #(.PORT_W(PORT_W), .DB_CYCLES(DB_CYCLES)) u_db1 (
        .clk(clk), .resetn(resetn), .pin(in_port1), .stable(stable1), .commit(commit1)
    );

    assign word = addr[7:2];
    assign clr0 = rd_en && (word == IO_PORT0_ADDR);
    assign clr1 = rd_en && (word == IO_PORT1_ADDR);

    // A commit landing on the same edge as a clearing read wins, so the
    // freshly committed value is still announced.
    assign new0_nxt = commit0 | (new0 & ~clr0);
    assign new1_nxt = commit1 | (new1 & ~clr1);

    always_comb begin
        rd_mux = 32'd0;
        case (word)
            IO_PORT0_ADDR:  rd_mux = {{(32-PORT_W){1'b0}}, stable0};
            IO_PORT1_ADDR:  rd_mux = {{(32-PORT_W){1'b0}}, stable1};
            IO_STATUS_ADDR: rd_mux = {30'd0, new1, new0};
            default:        rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            new0     <= 1'b0;
            new1     <= 1'b0;
            irq      <= 1'b0;
            io_data  <= 32'd0;
            rd_valid <= 1'b0;
        end else begin
            new0     <= new0_nxt;
            new1     <= new1_nxt;
            irq      <= new0_nxt | new1_nxt;
            rd_valid <= rd_en;
            if (rd_en) io_data <= rd_mux;
        end
    end

    // Display scan: each digit stays selected for SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            scan_cnt <= '0;
            index    <= 2'd0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            index    <= index + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign d0 = stable0 / PORT_W'(10);
    assign d1 = stable0 % PORT_W'(10);
    assign d2 = stable1 / PORT_W'(10);
    assign d3 = stable1 % PORT_W'(10);

    always_comb begin
        digit = 4'd0;
        case (index)
            2'd0: digit = 4'(d0);
            2'd1: digit = 4'(d1);
            2'd2: digit = 4'(d2);
            2'd3: digit = 4'(d3);
            default: digit = 4'd0;
        endcase
    end

    assign digit_sel = 4'b0001 << index;

    sevenseg u_seg (.digit(digit), .seg(seg));

endmodule

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl
//   Directed bench for io_input_ctrl with default parameters.
module tb_io_input_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] addr;
    logic        rd_en;
    logic [4:0]  in_port0, in_port1;
    logic [31:0] io_data;
    logic        rd_valid, irq;
    logic [3:0]  digit_sel;
    logic [6:0]  seg;

    int vectors    = 0;
    int miscompares = 0;

    io_input_ctrl dut (
        .clk(clk), .resetn(resetn), .addr(addr), .rd_en(rd_en),
        .in_port0(in_port0), .in_port1(in_port1),
        .io_data(io_data), .rd_valid(rd_valid), .irq(irq),
        .digit_sel(digit_sel), .seg(seg)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle read strobe; returns with the response registered.
    task automatic cpu_read(input logic [31:0] a);
        addr  = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'h3F;
            2: return 7'h5B;
            3: return 7'h4F;
            7: return 7'h07;
            default: return 7'h00;
        endcase
    endfunction

    initial begin
        int exp_dig[4];
        logic [3:0] one_hot;
        logic [3:0] prev_sel;
        bit found;
        exp_dig = '{2, 3, 0, 7};

        // Reset with pins at 17.
        resetn = 1'b0; addr = 32'd0; rd_en = 1'b0;
        in_port0 = 5'd17; in_port1 = 5'd17;
        #1;
        ticks(3);
        check("rst_io_data", io_data, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_digit_sel", {28'd0, digit_sel}, 32'h1);
        check("rst_seg", {25'd0, seg}, {25'd0, seg_code(0)});

        // Release: nothing commits in the first six edges.
        resetn = 1'b1;
        ticks(6);
        check("no_early_commit", {31'd0, irq}, 32'd0);

        // Reset mid-debounce with pins back to 0: nothing ever commits.
        resetn = 1'b0; in_port0 = 5'd0; in_port1 = 5'd0;
        tick();
        resetn = 1'b1;
        ticks(10);
        check("mid_db_reset_irq", {31'd0, irq}, 32'd0);
        cpu_read(32'h88);
        check("mid_db_reset_status", io_data, 32'd0);

        // Commit 23 on port 0 at edge 7.
        in_port0 = 5'd23;
        ticks(6);
        check("p0_edge6_irq", {31'd0, irq}, 32'd0);
        tick();
        check("p0_edge7_irq", {31'd0, irq}, 32'd1);
        cpu_read(32'h88);
        check("p0_status", io_data, 32'd1);
        check("p0_status_valid", {31'd0, rd_valid}, 32'd1);
        tick();
        check("rd_valid_drop", {31'd0, rd_valid}, 32'd0);
        check("io_data_hold", io_data, 32'd1);
        cpu_read(32'h80);
        check("p0_data", io_data, 32'd23);
        check("p0_irq_clear", {31'd0, irq}, 32'd0);
        cpu_read(32'h88);
        check("p0_status_clear", io_data, 32'd0);

        // Glitch on port 1: three cycles of 9 then back to 0.
        in_port1 = 5'd9;
        ticks(3);
        in_port1 = 5'd0;
        ticks(10);
        check("glitch_irq", {31'd0, irq}, 32'd0);
        cpu_read(32'h88);
        check("glitch_status", io_data, 32'd0);
        in_port1 = 5'd9;
        ticks(6);
        check("p1_edge6_irq", {31'd0, irq}, 32'd0);
        tick();
        check("p1_edge7_irq", {31'd0, irq}, 32'd1);
        cpu_read(32'h88);
        check("p1_status", io_data, 32'd2);
        cpu_read(32'h84);
        check("p1_data", io_data, 32'd9);

        // Collision: port 0 read on the same edge as commit 23 -> 30.
        in_port0 = 5'd30;
        ticks(6);
        cpu_read(32'h80);
        check("coll_old_data", io_data, 32'd23);
        check("coll_irq", {31'd0, irq}, 32'd1);
        cpu_read(32'h88);
        check("coll_flag_kept", io_data, 32'd1);
        cpu_read(32'h80);
        check("coll_new_data", io_data, 32'd30);
        cpu_read(32'h88);
        check("coll_flag_clear", io_data, 32'd0);

        // Display: stable0 = 23, stable1 = 7.
        in_port0 = 5'd23; in_port1 = 5'd7;
        ticks(8);
        cpu_read(32'h80);
        check("disp_p0", io_data, 32'd23);
        cpu_read(32'h84);
        check("disp_p1", io_data, 32'd7);
        found = 1'b0;
        prev_sel = digit_sel;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (digit_sel == 4'b0001 && prev_sel != 4'b0001) begin
                found = 1'b1;
                break;
            end
            prev_sel = digit_sel;
        end
        check("scan_sync_found", {31'd0, found}, 32'd1);
        if (found) begin
            for (int i = 0; i < 64; i++) begin
                one_hot = 4'b0001 << (i / 16);
                check($sformatf("scan_sel_%0d", i), {28'd0, digit_sel}, {28'd0, one_hot});
                check($sformatf("scan_seg_%0d", i), {25'd0, seg}, {25'd0, seg_code(exp_dig[i / 16])});
                tick();
            end
            check("scan_wrap_sel", {28'd0, digit_sel}, 32'h1);
            check("scan_wrap_seg", {25'd0, seg}, {25'd0, seg_code(2)});
        end

        // Unmapped read while new0 is set.
        in_port0 = 5'd5;
        ticks(8);
        check("p0_5_irq", {31'd0, irq}, 32'd1);
        cpu_read(32'h90);
        check("unmapped_data", io_data, 32'd0);
        check("unmapped_valid", {31'd0, rd_valid}, 32'd1);
        check("unmapped_irq", {31'd0, irq}, 32'd1);
        cpu_read(32'h88);
        check("unmapped_status", io_data, 32'd1);

        // Reset mid-debounce and mid-read: all state restarts.
        in_port1 = 5'd4;
        ticks(5);
        addr = 32'h84; rd_en = 1'b1; resetn = 1'b0;
        tick();
        rd_en = 1'b0; resetn = 1'b1;
        check("rst2_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst2_io_data", io_data, 32'd0);
        check("rst2_irq", {31'd0, irq}, 32'd0);
        tick();
        check("rst2_no_valid_after", {31'd0, rd_valid}, 32'd0);
        ticks(5);
        check("rst2_edge6_irq", {31'd0, irq}, 32'd0);
        tick();
        check("rst2_edge7_irq", {31'd0, irq}, 32'd1);
        cpu_read(32'h88);
        check("rst2_status", io_data, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
